// File: rtl/busrouter_if.sv
// Wishbone bundle between the requester, the router and its slaves.
// Router uses the slave modport; the requester/slave side uses master.
interface busrouter_if #(
    parameter int NSLAVES = 3,
    parameter int ADDR_W  = 7,
    parameter int SEL_W   = 3,
    parameter int DATA_W  = 32
);
    logic                        wb_stb_i;
    logic                        wb_cyc_i;
    logic                        wb_we_i;
    logic [ADDR_W-1:0]           wb_adr_i;
    logic [DATA_W-1:0]           wb_dat_i;
    logic [DATA_W-1:0]           wb_dat_o;
    logic                        wb_ack_o;
    logic                        wb_err_o;
    logic [NSLAVES-1:0]          s_wb_stb_o;
    logic                        s_wb_cyc_o;
    logic                        s_wb_we_o;
    logic [ADDR_W-SEL_W-1:0]     s_wb_adr_o;
    logic [DATA_W-1:0]           s_wb_dat_o;
    logic [NSLAVES*DATA_W-1:0]   s_wb_dat_i;
    logic [NSLAVES-1:0]          s_wb_ack_i;

    modport master (
        output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o,
        input  s_wb_stb_o, s_wb_cyc_o, s_wb_we_o, s_wb_adr_o, s_wb_dat_o,
        output s_wb_dat_i, s_wb_ack_i
    );

    modport slave (
        input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o,
        output s_wb_stb_o, s_wb_cyc_o, s_wb_we_o, s_wb_adr_o, s_wb_dat_o,
        input  s_wb_dat_i, s_wb_ack_i
    );
endinterface

// File: rtl/busrouter.sv
// Registered Wishbone router: decodes top address bits to one of NSLAVES.
// Define BUSROUTER_TIMEOUT_EN to add a watchdog that errors hung slaves.
module busrouter #(
    parameter int                         NSLAVES   = 3,
    parameter int                         ADDR_W    = 7,
    parameter int                         SEL_W     = 3,
    parameter int                         DATA_W    = 32,
    parameter logic [NSLAVES*SEL_W-1:0]   SLAVE_IDS = {3'h7, 3'h2, 3'h1},
    parameter int                         TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    busrouter_if.slave  bus
);
    localparam int SADR_W = ADDR_W - SEL_W;
    localparam int IDX_W  = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NSLAVES-1:0]   stb_q, stb_d;
    logic                 cyc_q, cyc_d;
    logic                 we_q, we_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic [SADR_W-1:0]    adr_q, adr_d;
    logic [DATA_W-1:0]    wdat_q, wdat_d;
    logic [DATA_W-1:0]    rdat_q, rdat_d;

    logic                 hit;
    logic [IDX_W-1:0]     hit_idx;
    logic                 sel_ack;
    logic [DATA_W-1:0]    sel_dat;
    logic                 req;

`ifdef BUSROUTER_TIMEOUT_EN
    logic [7:0]           cnt_q, cnt_d;
    logic                 tmo;
    assign tmo = (cnt_q + 8'd1) == 8'(TIMEOUT);
`endif

    assign req = bus.wb_stb_i & bus.wb_cyc_i;

    // Scan downward so the lowest matching index is the one kept.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if (bus.wb_adr_i[ADDR_W-1 -: SEL_W] ==
                SLAVE_IDS[i*SEL_W +: SEL_W]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        sel_ack = 1'b0;
        sel_dat = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_ack = bus.s_wb_ack_i[i];
                sel_dat = bus.s_wb_dat_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        stb_d   = stb_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
`ifdef BUSROUTER_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    we_d   = bus.wb_we_i;
                    adr_d  = bus.wb_adr_i[SADR_W-1:0];
                    wdat_d = bus.wb_dat_i;
                    if (hit) begin
                        idx_d   = hit_idx;
                        stb_d   = NSLAVES'(1) << hit_idx;
                        cyc_d   = 1'b1;
                        state_d = BUSY;
`ifdef BUSROUTER_TIMEOUT_EN
                        cnt_d   = 8'd0;
`endif
                    end else begin
                        err_d   = 1'b1;
                        rdat_d  = '0;
                        state_d = RESP;
                    end
                end
            end
            BUSY: begin
`ifdef BUSROUTER_TIMEOUT_EN
                cnt_d = cnt_q + 8'd1;
`endif
                // A dropped cycle abandons the transfer silently.
                if (!bus.wb_cyc_i) begin
                    stb_d   = '0;
                    cyc_d   = 1'b0;
                    state_d = IDLE;
                end else if (sel_ack) begin
                    ack_d   = 1'b1;
                    rdat_d  = we_q ? '0 : sel_dat;
                    stb_d   = '0;
                    cyc_d   = 1'b0;
                    state_d = RESP;
                end
`ifdef BUSROUTER_TIMEOUT_EN
                else if (tmo) begin
                    err_d   = 1'b1;
                    rdat_d  = '0;
                    stb_d   = '0;
                    cyc_d   = 1'b0;
                    state_d = RESP;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                stb_d   = '0;
                cyc_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            stb_q   <= '0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stb_q   <= stb_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

`ifdef BUSROUTER_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 8'd0;
        else     cnt_q <= cnt_d;
    end
`endif

    assign bus.wb_dat_o   = rdat_q;
    assign bus.wb_ack_o   = ack_q;
    assign bus.wb_err_o   = err_q;
    assign bus.s_wb_stb_o = stb_q;
    assign bus.s_wb_cyc_o = cyc_q;
    assign bus.s_wb_we_o  = we_q;
    assign bus.s_wb_adr_o = adr_q;
    assign bus.s_wb_dat_o = wdat_q;
endmodule

// File: tb/tb_busrouter.sv
// Directed bench for busrouter: reads, writes, unmapped, abort, reset.
// Timeout cases run only when BUSROUTER_TIMEOUT_EN is defined.
module tb_busrouter;
    localparam int NS = 3;
    localparam int AW = 7;
    localparam int SW = 3;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    busrouter_if #(.NSLAVES(NS), .ADDR_W(AW), .SEL_W(SW), .DATA_W(DW)) bus();

    busrouter #(
        .NSLAVES(NS), .ADDR_W(AW), .SEL_W(SW), .DATA_W(DW),
        .SLAVE_IDS(9'b111_010_001), .TIMEOUT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic we, input logic [AW-1:0] adr,
                       input logic [DW-1:0] dat);
        bus.wb_stb_i = 1'b1;
        bus.wb_cyc_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
    endtask

    task automatic drop();
        bus.wb_stb_i = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.wb_stb_i   = 1'b0;
        bus.wb_cyc_i   = 1'b0;
        bus.wb_we_i    = 1'b0;
        bus.wb_adr_i   = '0;
        bus.wb_dat_i   = '0;
        bus.s_wb_ack_i = '0;
        bus.s_wb_dat_i = {32'h0BAD0003, 32'h55AA0002, 32'hCAFE0001};
        step();
        step();
        chk("rst_dat", bus.wb_dat_o, 0);
        chk("rst_ack", bus.wb_ack_o, 0);
        chk("rst_err", bus.wb_err_o, 0);
        chk("rst_stb", bus.s_wb_stb_o, 0);
        chk("rst_cyc", bus.s_wb_cyc_o, 0);
        chk("rst_sdat", bus.s_wb_dat_o, 0);
        rst = 1'b0;

        // read slave index 0, zero wait
        req(1'b0, 7'h13, 32'h0);
        step();
        chk("rd_stb", bus.s_wb_stb_o, 3'b001);
        chk("rd_adr", bus.s_wb_adr_o, 4'h3);
        chk("rd_cyc", bus.s_wb_cyc_o, 1);
        chk("rd_ack_early", bus.wb_ack_o, 0);
        bus.s_wb_ack_i = 3'b001;
        step();
        bus.s_wb_ack_i = 3'b000;
        chk("rd_ack", bus.wb_ack_o, 1);
        chk("rd_err", bus.wb_err_o, 0);
        chk("rd_dat", bus.wb_dat_o, 32'hCAFE0001);
        chk("rd_stb_off", bus.s_wb_stb_o, 0);
        drop();
        step();
        chk("rd_ack_pulse", bus.wb_ack_o, 0);
        chk("rd_dat_hold", bus.wb_dat_o, 32'hCAFE0001);

        // unmapped address
        req(1'b0, 7'h40, 32'h0);
        step();
        chk("um_err", bus.wb_err_o, 1);
        chk("um_ack", bus.wb_ack_o, 0);
        chk("um_dat", bus.wb_dat_o, 0);
        chk("um_stb", bus.s_wb_stb_o, 0);
        drop();
        step();
        chk("um_err_pulse", bus.wb_err_o, 0);

        // write slave index 2 with three wait states
        req(1'b1, 7'h7A, 32'h12345678);
        step();
        chk("wr_stb", bus.s_wb_stb_o, 3'b100);
        chk("wr_we", bus.s_wb_we_o, 1);
        chk("wr_sdat", bus.s_wb_dat_o, 32'h12345678);
        chk("wr_adr", bus.s_wb_adr_o, 4'hA);
        bus.s_wb_ack_i = 3'b011;
        step();
        bus.s_wb_ack_i = 3'b000;
        chk("wr_wait2_ack", bus.wb_ack_o, 0);
        step();
        chk("wr_foreign_ack", bus.wb_ack_o, 0);
        chk("wr_stb_held", bus.s_wb_stb_o, 3'b100);
        step();
        chk("wr_wait4_ack", bus.wb_ack_o, 0);
        bus.s_wb_ack_i = 3'b100;
        step();
        bus.s_wb_ack_i = 3'b000;
        chk("wr_ack", bus.wb_ack_o, 1);
        chk("wr_dat_zero", bus.wb_dat_o, 0);
        drop();
        step();

        // abort in second busy cycle, then a normal transfer
        req(1'b0, 7'h25, 32'h0);
        step();
        chk("ab_stb1", bus.s_wb_stb_o, 3'b010);
        step();
        chk("ab_stb2", bus.s_wb_stb_o, 3'b010);
        drop();
        step();
        chk("ab_stb_off", bus.s_wb_stb_o, 0);
        chk("ab_cyc_off", bus.s_wb_cyc_o, 0);
        chk("ab_ack", bus.wb_ack_o, 0);
        chk("ab_err", bus.wb_err_o, 0);
        step();
        chk("ab_ack2", bus.wb_ack_o, 0);
        chk("ab_err2", bus.wb_err_o, 0);
        req(1'b0, 7'h25, 32'h0);
        step();
        chk("ab_new_stb", bus.s_wb_stb_o, 3'b010);
        bus.s_wb_ack_i = 3'b010;
        step();
        bus.s_wb_ack_i = 3'b000;
        chk("ab_new_ack", bus.wb_ack_o, 1);
        chk("ab_new_dat", bus.wb_dat_o, 32'h55AA0002);
        drop();
        step();

`ifdef BUSROUTER_TIMEOUT_EN
        req(1'b0, 7'h10, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("to_stb", bus.s_wb_stb_o, 3'b001);
            chk("to_err_early", bus.wb_err_o, 0);
        end
        step();
        chk("to_err", bus.wb_err_o, 1);
        chk("to_ack", bus.wb_ack_o, 0);
        chk("to_stb_off", bus.s_wb_stb_o, 0);
        drop();
        step();
        req(1'b0, 7'h10, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("to2_stb", bus.s_wb_stb_o, 3'b001);
        end
        bus.s_wb_ack_i = 3'b001;
        step();
        bus.s_wb_ack_i = 3'b000;
        chk("to2_ack", bus.wb_ack_o, 1);
        chk("to2_err", bus.wb_err_o, 0);
        chk("to2_dat", bus.wb_dat_o, 32'hCAFE0001);
        drop();
        step();
`else
        req(1'b0, 7'h10, 32'h0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("nt_stb", bus.s_wb_stb_o, 3'b001);
            chk("nt_err", bus.wb_err_o, 0);
        end
        bus.s_wb_ack_i = 3'b001;
        step();
        bus.s_wb_ack_i = 3'b000;
        chk("nt_ack", bus.wb_ack_o, 1);
        chk("nt_dat", bus.wb_dat_o, 32'hCAFE0001);
        drop();
        step();
`endif

        // reset while busy, then a normal write
        req(1'b1, 7'h13, 32'hDEADBEEF);
        step();
        chk("rb_stb", bus.s_wb_stb_o, 3'b001);
        rst = 1'b1;
        #1;
        chk("rb_stb0", bus.s_wb_stb_o, 0);
        chk("rb_cyc0", bus.s_wb_cyc_o, 0);
        chk("rb_we0", bus.s_wb_we_o, 0);
        chk("rb_sdat0", bus.s_wb_dat_o, 0);
        chk("rb_adr0", bus.s_wb_adr_o, 0);
        chk("rb_dat0", bus.wb_dat_o, 0);
        chk("rb_ack0", bus.wb_ack_o, 0);
        #1;
        rst = 1'b0;
        step();
        chk("rb_new_stb", bus.s_wb_stb_o, 3'b001);
        chk("rb_new_sdat", bus.s_wb_dat_o, 32'hDEADBEEF);
        bus.s_wb_ack_i = 3'b001;
        step();
        bus.s_wb_ack_i = 3'b000;
        chk("rb_new_ack", bus.wb_ack_o, 1);
        chk("rb_new_err", bus.wb_err_o, 0);
        drop();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
